// File: rtl/partition_resp_checker.sv
// partition_resp_checker: sweeps the partition pattern index over all 2^IN_W values,
// accepts one approximate output vector per index over a valid/ready handshake and
// accumulates mismatch count, total Hamming distance and maximum absolute error
// against the golden output presented alongside it.
// Optional macro RESP_CHECK_FIRST_FAIL_EN adds capture of the first mismatching
// transfer of a sweep (first_fail_valid/idx/resp/exp).
`timescale 1ns/1ps
module partition_resp_checker #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned OUT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [IN_W-1:0]       idx,
    input  logic                  resp_valid,
    output logic                  resp_ready,
    input  logic [OUT_W-1:0]      resp_data,
    input  logic [OUT_W-1:0]      exp_data,
    output logic                  busy,
    output logic                  done,
    output logic [IN_W:0]         err_count,
    output logic [IN_W+OUT_W-1:0] ham_sum,
    output logic [OUT_W-1:0]      max_abs_err
`ifdef RESP_CHECK_FIRST_FAIL_EN
    ,
    output logic                  first_fail_valid,
    output logic [IN_W-1:0]       first_fail_idx,
    output logic [OUT_W-1:0]      first_fail_resp,
    output logic [OUT_W-1:0]      first_fail_exp
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [IN_W-1:0] LastIdx = '1;

    logic [1:0]            state_q, state_d;
    logic                  xfer;
    logic                  sweep_start;
    logic                  mismatch;
    logic [OUT_W-1:0]      diff_bits;
    logic [OUT_W:0]        diff;
    logic [OUT_W-1:0]      abs_err;
    logic [IN_W+OUT_W-1:0] hd;

    // Handshake and status decode straight from the state register, so an async
    // reset drops them without waiting for a clock.
    always_comb begin
        xfer        = (state_q == StRun) && resp_valid;
        sweep_start = start && ((state_q == StIdle) || (state_q == StDone));
        resp_ready  = (state_q == StRun);
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
    end

    // Per-transfer error terms: XOR popcount and magnitude of the signed difference.
    always_comb begin
        diff_bits = resp_data ^ exp_data;
        mismatch  = |diff_bits;
        hd        = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            hd = hd + (IN_W+OUT_W)'(diff_bits[i]);
        end
        diff    = {1'b0, resp_data} - {1'b0, exp_data};
        abs_err = diff[OUT_W] ? OUT_W'(-diff) : diff[OUT_W-1:0];
    end

    // Next-state logic; start in RUN is deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (xfer && (idx == LastIdx)) state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // State, index and metric accumulation; idx wraps to 0 on the last transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx         <= '0;
            err_count   <= '0;
            ham_sum     <= '0;
            max_abs_err <= '0;
        end else begin
            state_q <= state_d;
            if (sweep_start) begin
                idx         <= '0;
                err_count   <= '0;
                ham_sum     <= '0;
                max_abs_err <= '0;
            end else if (xfer) begin
                idx       <= idx + 1'b1;
                err_count <= err_count + (IN_W+1)'(mismatch);
                ham_sum   <= ham_sum + hd;
                if (abs_err > max_abs_err) begin
                    max_abs_err <= abs_err;
                end
            end
        end
    end

`ifdef RESP_CHECK_FIRST_FAIL_EN
    // Capture only the first mismatch of a sweep; later ones leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_resp  <= '0;
            first_fail_exp   <= '0;
        end else if (sweep_start) begin
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_resp  <= '0;
            first_fail_exp   <= '0;
        end else if (xfer && mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= idx;
            first_fail_resp  <= resp_data;
            first_fail_exp   <= exp_data;
        end
    end
`endif

endmodule

// File: tb/tb_partition_resp_checker.sv
// Scoreboard bench for partition_resp_checker: each full sweep pushes its
// hand-computed final metrics; a monitor pops and compares on every rise of done.
`timescale 1ns/1ps
module tb_partition_resp_checker;

    localparam int IN_W  = 7;
    localparam int OUT_W = 4;
    localparam int N     = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IN_W-1:0]  idx;
    logic             resp_valid;
    logic             resp_ready;
    logic [OUT_W-1:0] resp_data;
    logic [OUT_W-1:0] exp_data;
    logic             busy;
    logic             done;
    logic [IN_W:0]    err_count;
    logic [IN_W+OUT_W-1:0] ham_sum;
    logic [OUT_W-1:0] max_abs_err;
`ifdef RESP_CHECK_FIRST_FAIL_EN
    logic             first_fail_valid;
    logic [IN_W-1:0]  first_fail_idx;
    logic [OUT_W-1:0] first_fail_resp;
    logic [OUT_W-1:0] first_fail_exp;
`endif

    partition_resp_checker #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .idx         (idx),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .exp_data    (exp_data),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .ham_sum     (ham_sum),
        .max_abs_err (max_abs_err)
`ifdef RESP_CHECK_FIRST_FAIL_EN
        ,
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .first_fail_resp  (first_fail_resp),
        .first_fail_exp   (first_fail_exp)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]  err;
        logic [10:0] ham;
        logic [3:0]  mx;
        logic        ffv;
        logic [6:0]  ffi;
        logic [3:0]  ffr;
        logic [3:0]  ffe;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Stimulus vectors per sweep mode.
    function automatic void gen(input int mode, input int i,
                                output logic [3:0] r, output logic [3:0] e);
        e = 4'(i);
        r = e;
        case (mode)
            1: r = e ^ 4'b0001;
            2: begin e = 4'h0; r = 4'hf; end
            3: begin
                if (i == 20) begin e = 4'd3; r = 4'd9; end
                else if (i == 90) r = e ^ 4'h6;
            end
            default: ;
        endcase
    endfunction

    // Hand-computed final metrics per sweep mode.
    function automatic exp_t expect_for(input int mode);
        exp_t x;
        x = '0;
        case (mode)
            1: begin x.err = 128; x.ham = 128; x.mx = 1;  x.ffv = 1; x.ffi = 0;  x.ffr = 1;  x.ffe = 0; end
            2: begin x.err = 128; x.ham = 512; x.mx = 15; x.ffv = 1; x.ffi = 0;  x.ffr = 15; x.ffe = 0; end
            3: begin x.err = 2;   x.ham = 4;   x.mx = 6;  x.ffv = 1; x.ffi = 20; x.ffr = 9;  x.ffe = 3; end
            default: ;
        endcase
        return x;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_idx"}, 32'(idx), 0);
        chk({tag, "_ready"}, 32'(resp_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_ham"}, 32'(ham_sum), 0);
        chk({tag, "_max"}, 32'(max_abs_err), 0);
`ifdef RESP_CHECK_FIRST_FAIL_EN
        chk({tag, "_ffv"}, 32'(first_fail_valid), 0);
`endif
    endtask

    task automatic sweep(input int mode, input int abort_at, input bit stall);
        logic [3:0] r;
        logic [3:0] e;
        int wait_n;
        if (abort_at < 0) sb.push_back(expect_for(mode));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_done", 32'(done), 0);
        chk("start_err", 32'(err_count), 0);
        chk("start_max", 32'(max_abs_err), 0);
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                resp_valid = 1'b0;
                chk("abort_idx", 32'(idx), 32'(i));
                #2 rst = 1'b1;
                #1 chk_reset_vals("async_rst");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (stall && i == 37) begin
                resp_valid = 1'b0;
                resp_data  = 4'hf;
                exp_data   = 4'h0;
                for (int k = 0; k < 10; k++) begin
                    start = (k == 4);
                    @(posedge clk); #1;
                end
                start = 1'b0;
                chk("stall_idx", 32'(idx), 37);
                chk("stall_err", 32'(err_count), 37);
                chk("stall_ham", 32'(ham_sum), 37);
                chk("stall_max", 32'(max_abs_err), 1);
                chk("stall_busy", 32'(busy), 1);
            end
            gen(mode, i, r, e);
            resp_valid = 1'b1;
            resp_data  = r;
            exp_data   = e;
            chk("xfer_idx", 32'(idx), 32'(i));
            chk("xfer_ready", 32'(resp_ready), 1);
            @(posedge clk); #1;
        end
        resp_valid = 1'b0;
        wait_n = 0;
        while (!done && wait_n < 4) begin
            @(posedge clk); #1;
            wait_n++;
        end
        chk("done_seen", 32'(done), 1);
        chk("done_idx", 32'(idx), 0);
        chk("done_ready", 32'(resp_ready), 0);
        chk("done_busy", 32'(busy), 0);
    endtask

    // Monitor: compare final metrics against the scoreboard when done rises.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 0);
            end else begin
                x = sb.pop_front();
                chk("sb_err", 32'(err_count), 32'(x.err));
                chk("sb_ham", 32'(ham_sum), 32'(x.ham));
                chk("sb_max", 32'(max_abs_err), 32'(x.mx));
`ifdef RESP_CHECK_FIRST_FAIL_EN
                chk("sb_ffv", 32'(first_fail_valid), 32'(x.ffv));
                if (x.ffv) begin
                    chk("sb_ffi", 32'(first_fail_idx), 32'(x.ffi));
                    chk("sb_ffr", 32'(first_fail_resp), 32'(x.ffr));
                    chk("sb_ffe", 32'(first_fail_exp), 32'(x.ffe));
                end
`endif
            end
        end
        done_prev <= done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        exp_data   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals("reset");

        // resp_valid in IDLE must not move anything.
        resp_valid = 1'b1;
        resp_data  = 4'hf;
        exp_data   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        resp_valid = 1'b0;
        chk_reset_vals("idle_valid");

        sweep(0, -1, 1'b0);
        sweep(1, -1, 1'b0);
        sweep(2, -1, 1'b0);
        sweep(1, -1, 1'b1);
        sweep(1, 64, 1'b0);
        sweep(1, -1, 1'b0);
        sweep(3, -1, 1'b0);

        @(posedge clk); #1;
        chk("done_hold_err", 32'(err_count), 2);
`ifdef RESP_CHECK_FIRST_FAIL_EN
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_ffv", 32'(first_fail_valid), 0);
        chk("restart_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
